// File: rtl/uart_rx_async.sv
// Asynchronous UART receiver with 16x oversampling, optional parity and stop-bit check.
// Bytes go to a holding register (RX_FIFO=0) or out through a FIFO write strobe (RX_FIFO=1).
module uart_rx_async #(
    parameter bit RX_FIFO = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       baud_clock_i,
    input  logic       rx_i,
    input  logic       bit8_i,
    input  logic       parity_en_i,
    input  logic       odd_n_even_i,
    input  logic       read_rx_byte_i,
    input  logic       clear_errors_i,
    input  logic       fifo_full_i,
    input  logic       fifo_empty_i,
    output logic [7:0] rx_byte_o,
    output logic       rxrdy_o,
    output logic       parity_err_o,
    output logic       framing_err_o,
    output logic       overflow_o,
    output logic       fifo_write_o
);

    typedef enum logic [2:0] {
        StIdle, StStartCheck, StDataBits, StParity, StStop, StStore, StBreakWait
    } state_e;

    state_e     state_q, state_d;
    logic       rx_meta_q, rx_s_q;
    logic [3:0] samp_cnt_q, samp_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       par_err_q, par_err_d;
    logic       frm_err_q, frm_err_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rxrdy_q, rxrdy_d;
    logic       parity_err_q, parity_err_d;
    logic       framing_err_q, framing_err_d;
    logic       overflow_q, overflow_d;
    logic       fifo_write_q, fifo_write_d;
    logic       last_bit, store, lost;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        last_bit   = bit8_i ? (bit_cnt_q == 3'd7) : (bit_cnt_q == 3'd6);
        unique case (state_q)
            StIdle: begin
                samp_cnt_d = '0;
                if (baud_clock_i && !rx_s_q) begin
                    state_d   = StStartCheck;
                    shift_d   = '0;
                    par_d     = 1'b0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            StStartCheck: begin
                if (baud_clock_i) begin
                    if (samp_cnt_q == 4'd7) begin
                        samp_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s_q ? StIdle : StDataBits;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 4'd1;
                    end
                end
            end
            StDataBits: begin
                if (baud_clock_i) begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == 4'd15) begin
                        shift_d[bit_cnt_q] = rx_s_q;
                        par_d              = par_q ^ rx_s_q;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            state_d = parity_en_i ? StParity : StStop;
                        end
                    end
                end
            end
            StParity: begin
                if (baud_clock_i) begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == 4'd15) begin
                        par_err_d = rx_s_q != (odd_n_even_i ^ par_q);
                        state_d   = StStop;
                    end
                end
            end
            StStop: begin
                if (baud_clock_i) begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == 4'd15) begin
                        frm_err_d = !rx_s_q;
                        state_d   = StStore;
                    end
                end
            end
            // Single-clk state; a baud tick landing here is deliberately dropped.
            StStore: state_d = frm_err_q ? StBreakWait : StIdle;
            StBreakWait: begin
                if (baud_clock_i && rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        store     = (state_q == StStore);
        rx_byte_d = store ? {bit8_i & shift_q[7], shift_q[6:0]} : rx_byte_q;
        if (RX_FIFO) begin
            lost         = store && fifo_full_i;
            rxrdy_d      = !fifo_empty_i;
            fifo_write_d = !(store && !fifo_full_i);
        end else begin
            lost         = store && rxrdy_q && !read_rx_byte_i;
            rxrdy_d      = store || (rxrdy_q && !read_rx_byte_i);
            fifo_write_d = 1'b1;
        end
        parity_err_d  = (store && par_err_q) || (parity_err_q && !clear_errors_i);
        framing_err_d = (store && frm_err_q) || (framing_err_q && !clear_errors_i);
        overflow_d    = lost || (overflow_q && !clear_errors_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            samp_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            par_err_q     <= 1'b0;
            frm_err_q     <= 1'b0;
            rx_byte_q     <= '0;
            rxrdy_q       <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
            fifo_write_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            samp_cnt_q    <= samp_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            par_err_q     <= par_err_d;
            frm_err_q     <= frm_err_d;
            rx_byte_q     <= rx_byte_d;
            rxrdy_q       <= rxrdy_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            overflow_q    <= overflow_d;
            fifo_write_q  <= fifo_write_d;
        end
    end

    assign rx_byte_o     = rx_byte_q;
    assign rxrdy_o       = rxrdy_q;
    assign parity_err_o  = parity_err_q;
    assign framing_err_o = framing_err_q;
    assign overflow_o    = overflow_q;
    assign fifo_write_o  = fifo_write_q;

endmodule

// File: tb/tb_uart_rx_async.sv
// Bench for uart_rx_async: one holding-register and one FIFO-mode instance share the rx line,
// checked against a frame-level model of what each frame should deliver.
module tb_uart_rx_async;

    logic       clk, rst_n, baud, rx, bit8, parity_en, odd_n_even;
    logic       read_rx_byte, clear_errors, fifo_full, fifo_empty;
    logic [7:0] rx_byte0, rx_byte1;
    logic       rxrdy0, rxrdy1, perr0, perr1, ferr0, ferr1, ovf0, ovf1, fw0, fw1;

    int         tests = 0;
    int         fails = 0;
    int         ncyc = 0;
    int         read_at = -1;
    int         clr_at = -1;
    int         strobes0 = 0;
    int         strobes1 = 0;
    logic [7:0] strobe_byte = 8'h00;

    // Model state
    logic [7:0] exp_byte, exp_strobe_byte;
    bit         exp_rdy0, exp_perr, exp_ferr, exp_ovf0, exp_ovf1;
    int         exp_strobes;

    uart_rx_async #(.RX_FIFO(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .baud_clock_i(baud), .rx_i(rx), .bit8_i(bit8),
        .parity_en_i(parity_en), .odd_n_even_i(odd_n_even), .read_rx_byte_i(read_rx_byte),
        .clear_errors_i(clear_errors), .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty),
        .rx_byte_o(rx_byte0), .rxrdy_o(rxrdy0), .parity_err_o(perr0), .framing_err_o(ferr0),
        .overflow_o(ovf0), .fifo_write_o(fw0)
    );

    uart_rx_async #(.RX_FIFO(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .baud_clock_i(baud), .rx_i(rx), .bit8_i(bit8),
        .parity_en_i(parity_en), .odd_n_even_i(odd_n_even), .read_rx_byte_i(read_rx_byte),
        .clear_errors_i(clear_errors), .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty),
        .rx_byte_o(rx_byte1), .rxrdy_o(rxrdy1), .parity_err_o(perr1), .framing_err_o(ferr1),
        .overflow_o(ovf1), .fifo_write_o(fw1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // baud is high for the rising edge that follows every 4th falling edge
    initial begin
        baud = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            baud = (ncyc % 4 == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (fw0 === 1'b0) strobes0++;
            if (fw1 === 1'b0) begin
                strobes1++;
                strobe_byte = rx_byte1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        read_rx_byte = (ncyc == read_at);
        clear_errors = (ncyc == clr_at);
    endtask

    task automatic wait_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_steps(64);
    endtask

    task automatic do_read();
        read_at = ncyc + 1;
        wait_steps(2);
        exp_rdy0 = 1'b0;
    endtask

    task automatic do_clear();
        clr_at = ncyc + 1;
        wait_steps(2);
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf0 = 1'b0;
        exp_ovf1 = 1'b0;
    endtask

    task automatic model_reset();
        exp_byte = 8'h00;
        exp_rdy0 = 1'b0;
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf0 = 1'b0;
        exp_ovf1 = 1'b0;
    endtask

    // rd_same: pulse read_rx_byte in the very clk the byte is stored
    task automatic send_frame(input logic [7:0] data, input bit b8, input bit pen, input bit odd,
                              input bit bad_par, input bit stop_v, input bit rd_same);
        int         nb, s;
        logic       pbit;
        logic [7:0] byte_v;
        nb   = b8 ? 8 : 7;
        pbit = odd;
        for (int i = 0; i < nb; i++) pbit ^= data[i];
        pbit ^= bad_par;
        bit8       = b8;
        parity_en  = pen;
        odd_n_even = odd;
        while (ncyc % 4 != 0) step();
        s = ncyc;
        // start detected 4 clks after the edge; stop sampled 8+16*(bits+1) ticks later
        if (rd_same) read_at = s + 4 + 4 * (8 + 16 * (nb + (pen ? 1 : 0) + 1)) + 1;
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(data[i]);
        if (pen) send_bit(pbit);
        send_bit(stop_v);
        byte_v = b8 ? data : {1'b0, data[6:0]};
        if (exp_rdy0 && !rd_same) exp_ovf0 = 1'b1;
        exp_rdy0 = 1'b1;
        exp_byte = byte_v;
        if (pen && bad_par) exp_perr = 1'b1;
        if (!stop_v) exp_ferr = 1'b1;
        if (fifo_full) exp_ovf1 = 1'b1;
        else begin
            exp_strobes++;
            exp_strobe_byte = byte_v;
        end
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s.byte0", tag), rx_byte0, exp_byte);
        check($sformatf("%s.rxrdy0", tag), {7'b0, rxrdy0}, {7'b0, exp_rdy0});
        check($sformatf("%s.perr0", tag), {7'b0, perr0}, {7'b0, exp_perr});
        check($sformatf("%s.ferr0", tag), {7'b0, ferr0}, {7'b0, exp_ferr});
        check($sformatf("%s.ovf0", tag), {7'b0, ovf0}, {7'b0, exp_ovf0});
        check($sformatf("%s.byte1", tag), rx_byte1, exp_byte);
        check($sformatf("%s.perr1", tag), {7'b0, perr1}, {7'b0, exp_perr});
        check($sformatf("%s.ferr1", tag), {7'b0, ferr1}, {7'b0, exp_ferr});
        check($sformatf("%s.ovf1", tag), {7'b0, ovf1}, {7'b0, exp_ovf1});
        check($sformatf("%s.fw_idle", tag), {6'b0, fw0, fw1}, 8'h03);
        check($sformatf("%s.strobes1", tag), 8'(strobes1), 8'(exp_strobes));
        check($sformatf("%s.strobes0", tag), 8'(strobes0), 8'h00);
        if (exp_strobes > 0)
            check($sformatf("%s.strobe_byte", tag), strobe_byte, exp_strobe_byte);
    endtask

    initial begin
        logic [7:0] d;
        bit         b8, pen, odd, bad;
        rst_n = 1'b0; rx = 1'b1; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        read_rx_byte = 1'b0; clear_errors = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
        exp_strobes = 0; exp_strobe_byte = 8'h00;
        model_reset();
        wait_steps(4);
        check_all("reset");
        check("reset.rxrdy1", {7'b0, rxrdy1}, 8'h00);
        rst_n = 1'b1;
        wait_steps(40);

        // 8N1 0xA5
        send_frame(8'hA5, 1, 0, 0, 0, 1, 0);
        check_all("a5");
        do_read();
        check("a5.read", {7'b0, rxrdy0}, 8'h00);

        // 7O1 0x53, good then bad parity; error stays until cleared
        send_frame(8'h53, 0, 1, 1, 0, 1, 0);
        check_all("p_ok");
        do_read();
        send_frame(8'h53, 0, 1, 1, 1, 1, 0);
        check_all("p_bad");
        do_read();
        send_frame(8'hA5, 1, 0, 0, 0, 1, 0);
        check_all("p_sticky");
        do_read();
        do_clear();
        check_all("p_clear");

        // Break: stop bit low then line held low for 3 frame times
        send_frame(8'h00, 1, 0, 0, 0, 0, 0);
        wait_steps(3 * 640);
        check_all("break");
        do_read();
        rx = 1'b1;
        wait_steps(128);
        send_frame(8'h3C, 1, 0, 0, 0, 1, 0);
        check_all("after_break");
        do_read();
        do_clear();

        // Overrun in holding-register mode, back-to-back frames
        send_frame(8'h11, 1, 0, 0, 0, 1, 0);
        send_frame(8'h22, 1, 0, 0, 0, 1, 0);
        check_all("ovf");
        do_read();
        do_clear();
        send_frame(8'h33, 1, 0, 0, 0, 1, 0);
        send_frame(8'h44, 1, 0, 0, 0, 1, 1);
        check_all("rd_same");
        do_read();

        // FIFO mode strobe, then FIFO full
        send_frame(8'h7E, 1, 0, 0, 0, 1, 0);
        check_all("fifo_7e");
        do_read();
        fifo_full = 1'b1;
        send_frame(8'h5A, 1, 0, 0, 0, 1, 0);
        check_all("fifo_full");
        fifo_full = 1'b0;
        do_read();
        do_clear();

        fifo_empty = 1'b0;
        check("fe.before", {7'b0, rxrdy1}, 8'h00);
        step();
        check("fe.rise", {7'b0, rxrdy1}, 8'h01);
        fifo_empty = 1'b1;
        check("fe.hold", {7'b0, rxrdy1}, 8'h01);
        step();
        check("fe.fall", {7'b0, rxrdy1}, 8'h00);

        // 4-tick glitch is rejected
        rx = 1'b0;
        wait_steps(16);
        rx = 1'b1;
        wait_steps(200);
        check_all("glitch");

        // Randomized frames
        for (int i = 0; i < 10; i++) begin
            d   = 8'($urandom);
            b8  = 1'($urandom % 2);
            pen = 1'($urandom % 2);
            odd = 1'($urandom % 2);
            bad = ($urandom % 3 == 0);
            send_frame(d, b8, pen, odd, bad, 1, 0);
            check_all($sformatf("rnd%0d", i));
            do_read();
            if (exp_perr) do_clear();
        end

        // Reset in the middle of a data bit
        send_frame(8'h96, 1, 1, 0, 1, 1, 0);
        check_all("pre_rst");
        while (ncyc % 4 != 0) step();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b1;
        wait_steps(20);
        rst_n = 1'b0;
        model_reset();
        step();
        check_all("mid_rst");
        check("mid_rst.rxrdy1", {7'b0, rxrdy1}, 8'h00);
        rst_n = 1'b1;
        wait_steps(128);
        send_frame(8'hC3, 1, 0, 0, 0, 1, 0);
        check_all("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
